// File: rtl/if_id_queue_pkg.sv
// Shared fetch/decode definitions for the pipeline.
// Bus widths, enable levels and reset words used by several stages.
package if_id_queue_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam int IfIdDepth   = 2;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam logic [InstAddrBus-1:0] ZeroWord = '0;
  localparam logic [InstBus-1:0]     NopInst  = 32'h0000_0000;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } if_id_t;

endpackage

// File: rtl/if_id_queue.sv
// Fetch-to-decode FIFO stage holding {pc, inst} pairs.
// Registered-count backpressure; flush empties the queue in one cycle.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = IfIdDepth,
  parameter int AW    = InstAddrBus,
  parameter int DW    = InstBus
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       if_ce,
  input  logic [AW-1:0]              if_pc,
  input  logic [DW-1:0]              if_inst,
  output logic                       if_ready,
  input  logic                       flush,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [AW-1:0]              id_pc,
  output logic [DW-1:0]              id_inst,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] pc_mem   [DEPTH];
  logic [DW-1:0] inst_mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign if_ready = (count < FULL);
  assign id_valid = (count != '0);

  assign push = (if_ce == ChipEnable) && if_ready && !flush;
  assign pop  = id_valid && id_ready && !flush;

  // Empty queue presents a NOP at address zero to decode.
  assign id_pc   = id_valid ? pc_mem[rd_ptr]   : ZeroWord[AW-1:0];
  assign id_inst = id_valid ? inst_mem[rd_ptr] : NopInst[DW-1:0];

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= if_pc;
      inst_mem[wr_ptr] <= if_inst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue.
// Hand-computed vectors: reset, fill, stream, flush, async reset.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_ce;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        flush;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [1:0]  count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_id_queue dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_ce    (if_ce),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_ready (if_ready),
    .flush    (flush),
    .id_ready (id_ready),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .count    (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    if_ce   = 1'b1;
    if_pc   = pc;
    if_inst = 32'h1000_0000 | pc;
  endtask

  initial begin
    rst_n    = 1'b0;
    if_ce    = 1'b0;
    if_pc    = '0;
    if_inst  = '0;
    flush    = 1'b0;
    id_ready = 1'b0;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_inst",  id_inst,       32'h0);
    chk("rst_pc",    id_pc,         32'h0);
    chk("rst_ready", 32'(if_ready), 32'd1);
    chk("rst_count", 32'(count),    32'd0);

    // single fetch
    if_ce   = 1'b1;
    if_pc   = 32'h0000_0004;
    if_inst = 32'h3401_1100;
    tick();
    if_ce = 1'b0;
    chk("one_valid", 32'(id_valid), 32'd1);
    chk("one_pc",    id_pc,         32'h4);
    chk("one_inst",  id_inst,       32'h3401_1100);
    chk("one_count", 32'(count),    32'd1);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    chk("drain_count", 32'(count), 32'd0);

    // fill to full, third push dropped
    fetch(32'h0);
    tick();
    chk("fill1_count", 32'(count), 32'd1);
    fetch(32'h4);
    tick();
    chk("fill2_count", 32'(count),    32'd2);
    chk("fill2_ready", 32'(if_ready), 32'd0);
    fetch(32'h8);
    tick();
    chk("full_count", 32'(count), 32'd2);
    chk("full_head",  id_pc,      32'h0);
    chk("full_inst",  id_inst,    32'h1000_0000);

    // flush with simultaneous push and pop
    flush    = 1'b1;
    id_ready = 1'b1;
    fetch(32'h10);
    tick();
    flush    = 1'b0;
    if_ce    = 1'b0;
    id_ready = 1'b0;
    chk("fl_count", 32'(count),    32'd0);
    chk("fl_valid", 32'(id_valid), 32'd0);
    chk("fl_inst",  id_inst,       32'h0);
    chk("fl_ready", 32'(if_ready), 32'd1);
    tick();
    chk("fl_nopc10", 32'(id_valid), 32'd0);

    // streaming one per cycle
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch(32'(i * 4));
      tick();
      chk("st_pc",    id_pc,      32'(i * 4));
      chk("st_count", 32'(count), 32'd1);
    end
    if_ce = 1'b0;
    tick();
    id_ready = 1'b0;
    chk("st_end", 32'(count), 32'd0);

    // async reset with count==2
    fetch(32'h40);
    tick();
    fetch(32'h44);
    tick();
    if_ce = 1'b0;
    chk("ar_pre", 32'(count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(id_valid), 32'd0);
    chk("ar_count", 32'(count),    32'd0);
    chk("ar_ready", 32'(if_ready), 32'd1);
    rst_n = 1'b1;
    fetch(32'h20);
    tick();
    if_ce = 1'b0;
    chk("ar_push_valid", 32'(id_valid), 32'd1);
    chk("ar_push_pc",    id_pc,         32'h20);
    chk("ar_push_count", 32'(count),    32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Fetch-to-decode decoupling stage of the MIPS CPU pipeline. Sits directly downstream of the PC register and instruction ROM.
- Captures each fetched {pc, instruction} pair while the fetch chip-enable is active and holds it in a small FIFO.
- Presents the oldest entry to the decode stage with a valid/ready handshake.
- Backpressures fetch when full; supports flush for branch redirect.

Parameters:
- DEPTH, 2, number of queued entries (power of two, >=2)
- AW, 32, instruction address width (matches `InstAddrBus`)
- DW, 32, instruction word width (matches `InstBus`)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- if_ce  in  1  fetch chip-enable from PC stage; `ChipEnable` = fetch valid this cycle
- if_pc  in  AW  address of the current fetch
- if_inst  in  DW  ROM read data for if_pc (combinational ROM, same cycle)
- if_ready  out  1  queue can accept; upstream PC must hold while low
- flush  in  1  discard all queued entries (branch/exception redirect)
- id_ready  in  1  decode accepts head entry this cycle
- id_valid  out  1  head entry present
- id_pc  out  AW  head entry address; `ZeroWord` when empty
- id_inst  out  DW  head entry instruction; NOP (32'h0000_0000) when empty
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, rst_n low): count=0, write and read pointers=0, id_valid=0, id_pc=0, id_inst=0, if_ready=1. Storage contents are don't-care.
- Push condition: if_ce==`ChipEnable` && if_ready && !flush. Writes {if_pc, if_inst} at wr_ptr, then wr_ptr+1.
- Pop condition: id_valid && id_ready && !flush. Advances rd_ptr by 1.
- Pointers wrap modulo DEPTH.
- count updates as follows:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- if_ready = (count < DEPTH), derived from registered count only. There is no combinational path from id_ready to if_ready. When full, a same-cycle pop does not enable a push.
- id_valid = (count != 0).
- id_pc/id_inst read combinationally from storage at rd_ptr, gated to 0 when empty.
- Latency: a push into an empty queue is visible on id_* the next cycle. There is no bypass.
- Full (count==DEPTH): if_ready=0, if_ce ignored, no overwrite.
- Empty: id_valid=0, id_ready ignored, outputs show NOP/0.
- Flush:
  - Has priority over push and pop in the same cycle.
  - Next cycle: count=0, both pointers=0, id_valid=0, if_ready=1.
  - A fetch presented in the flush cycle is discarded.
- Back-to-back streaming at count==1 with id_ready=1 and if_ce=1 sustains one instruction per cycle.
- Reset asserted mid-operation clears state immediately (asynchronous). The first push is possible on the first rising edge after rst_n rises.
- if_pc is stored as given; the block performs no alignment check.

Decomposition:
- Shared defines file: `InstAddrBus`, `InstBus`, `ChipEnable`, `ChipDisable`, `ZeroWord`, `NopInst`.
- Add `IfIdDepth` there if other stages need it.
- Single module; storage is a small register array inside it. No sub-module is warranted.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, release.
  - Required: id_valid=0, id_inst=0, id_pc=0, if_ready=1, count=0.
- Single fetch: if_ce=1, if_pc=0x0000_0004, if_inst=0x3401_1100 for one cycle, id_ready=0.
  - Next cycle: id_valid=1, id_pc=0x4, id_inst=0x3401_1100, count=1.
- Fill to full: push pc 0x0, 0x4, 0x8 on consecutive cycles with id_ready=0.
  - count=2 after two pushes; if_ready=0.
  - Third push dropped; head remains pc 0x0.
- Streaming: id_ready=1, push pc 0x0,0x4,0x8,0xC every cycle.
  - Decode sees 0x0,0x4,0x8,0xC on consecutive cycles starting 1 cycle after the first push; count stays 1.
- Flush with simultaneous push and pop: count=2, flush=1, if_ce=1 (pc 0x10), id_ready=1.
  - Next cycle: count=0, id_valid=0, id_inst=0.
  - pc 0x10 never appears at decode.
- Async reset mid-stream: rst_n low between clock edges with count=2.
  - id_valid and count drop to 0 immediately, without waiting for a clock edge.
  - After release, the first push (pc 0x20) appears one cycle later.
